// File: rtl/dfft_sched_pkg.sv
// Shared types and defaults for the DFFT pulse scheduler: FSM state encoding,
// default timing constants and the round-robin index helper.
package dfft_sched_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_INIT   = 3'd0;
   localparam state_t ST_IDLE   = 3'd1;
   localparam state_t ST_LOAD   = 3'd2;
   localparam state_t ST_SETTLE = 3'd3;
   localparam state_t ST_FIRE   = 3'd4;
   localparam state_t ST_RECOV  = 3'd5;

   localparam int GAP_CYC_DEF   = 2;
   localparam int BEGIN_CYC_DEF = 8;

   function automatic int next_idx(input int idx, input int n);
      return (idx + 1 == n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/dfft_pulse_sched_if.sv
// Requester-side bundle of the DFFT pulse scheduler: level requests with data
// bits in, one-hot completion strobe and predicted cell response out.
interface dfft_pulse_sched_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] req_bit;
   logic [N_REQ-1:0] ack;
   logic             resp_q;

   modport master (output req, output req_bit, input ack, input resp_q);
   modport slave  (input req, input req_bit, output ack, output resp_q);
endinterface

// File: rtl/dfft_pulse_sched_rr_arbiter.sv
// Round-robin selector: one-hot grant of the lowest requester at or above the
// pointer, wrapping to the lowest requester overall.
module rr_arbiter #(
   parameter int N_REQ = 4,
   localparam int PTR_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N_REQ-1:0] grant
);
   logic [N_REQ-1:0] hi_mask;
   logic [N_REQ-1:0] masked;
   logic [N_REQ-1:0] pick;

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_mask
         assign hi_mask[gi] = (PTR_W'(gi) >= ptr);
      end
   endgenerate

   assign masked = req & hi_mask;
   assign pick   = (|masked) ? masked : req;
   // Isolate the lowest set bit of the chosen vector.
   assign grant  = pick & (~pick + N_REQ'(1));
endmodule

// File: rtl/dfft_pulse_sched.sv
// Pulse scheduler sharing one DFFT cell among N_REQ requesters via toggle-encoded
// a/clk pulse lines. Define DFFT_SCHED_MIRROR_EN to build the cell-state mirror.
module dfft_pulse_sched
   import dfft_sched_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int GAP_CYC   = GAP_CYC_DEF,
   parameter int BEGIN_CYC = BEGIN_CYC_DEF,
   localparam int PTR_W    = $clog2(N_REQ)
) (
   input  logic                clk,
   input  logic                rst,
   dfft_pulse_sched_if.slave   bus,
   output logic                a_tgl,
   output logic                clk_tgl,
   output logic                q_mirror,
   output logic                busy
);
   generate
      if (N_REQ < 2 || N_REQ > 16) begin : g_bad_nreq
         $error("dfft_pulse_sched: N_REQ must be within 2..16");
      end
      if (GAP_CYC < 1) begin : g_bad_gap
         $error("dfft_pulse_sched: GAP_CYC must be >= 1");
      end
      if (BEGIN_CYC < 1) begin : g_bad_begin
         $error("dfft_pulse_sched: BEGIN_CYC must be >= 1");
      end
   endgenerate

   state_t           state_reg;
   logic [15:0]      cnt_reg;
   logic [PTR_W-1:0] ptr_reg;
   logic [PTR_W-1:0] idx_reg;
   logic [PTR_W-1:0] grant_idx;
   logic [N_REQ-1:0] grant;
   logic [N_REQ-1:0] idx_onehot;
   logic [N_REQ-1:0] ack_reg;
   logic             a_reg;
   logic             clk_reg;
   logic             grant_bit;
   logic             a_fire;
   logic             clk_fire;

   rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .req   (bus.req),
      .ptr   (ptr_reg),
      .grant (grant)
   );

   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) grant_idx = PTR_W'(i);
      end
   end

   assign grant_bit  = |(grant & bus.req_bit);
   assign idx_onehot = N_REQ'(1) << idx_reg;

   // At most one of these is ever set, so a and clk pulses never share a cycle.
   always_comb begin
      a_fire   = 1'b0;
      clk_fire = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            a_fire   = (|bus.req) & grant_bit;
            clk_fire = (|bus.req) & ~grant_bit;
         end
         ST_LOAD:   clk_fire = (GAP_CYC == 1);
         ST_SETTLE: clk_fire = (cnt_reg == 16'(GAP_CYC - 2));
         default:   ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_INIT;
         cnt_reg   <= '0;
         ptr_reg   <= '0;
         idx_reg   <= '0;
         ack_reg   <= '0;
         a_reg     <= 1'b0;
         clk_reg   <= 1'b0;
      end else begin
         ack_reg <= '0;
         case (state_reg)
            ST_INIT: begin
               if (cnt_reg == 16'(BEGIN_CYC - 1)) begin
                  cnt_reg   <= '0;
                  state_reg <= ST_IDLE;
               end else begin
                  cnt_reg <= cnt_reg + 16'd1;
               end
            end
            ST_IDLE: begin
               if (a_fire) begin
                  idx_reg   <= grant_idx;
                  a_reg     <= ~a_reg;
                  state_reg <= ST_LOAD;
               end else if (clk_fire) begin
                  idx_reg   <= grant_idx;
                  clk_reg   <= ~clk_reg;
                  ack_reg   <= grant;
                  state_reg <= ST_FIRE;
               end
            end
            ST_LOAD: begin
               cnt_reg <= '0;
               if (clk_fire) begin
                  clk_reg   <= ~clk_reg;
                  ack_reg   <= idx_onehot;
                  state_reg <= ST_FIRE;
               end else begin
                  state_reg <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (clk_fire) begin
                  cnt_reg   <= '0;
                  clk_reg   <= ~clk_reg;
                  ack_reg   <= idx_onehot;
                  state_reg <= ST_FIRE;
               end else begin
                  cnt_reg <= cnt_reg + 16'd1;
               end
            end
            ST_FIRE: begin
               ptr_reg   <= PTR_W'(next_idx(int'(idx_reg), N_REQ));
               cnt_reg   <= '0;
               state_reg <= ST_RECOV;
            end
            ST_RECOV: begin
               if (cnt_reg == 16'(GAP_CYC - 1)) begin
                  cnt_reg   <= '0;
                  state_reg <= ST_IDLE;
               end else begin
                  cnt_reg <= cnt_reg + 16'd1;
               end
            end
            default: begin
               cnt_reg   <= '0;
               state_reg <= ST_INIT;
            end
         endcase
      end
   end

`ifdef DFFT_SCHED_MIRROR_EN
   logic mirror_reg;
   logic q_reg;
   logic resp_reg;

   // Model of the cell: a-pulse stores a 1, clk-pulse reads it out destructively.
   always_ff @(posedge clk) begin
      if (rst) begin
         mirror_reg <= 1'b0;
         q_reg      <= 1'b0;
         resp_reg   <= 1'b0;
      end else begin
         resp_reg <= 1'b0;
         if (a_fire) begin
            mirror_reg <= 1'b1;
         end else if (clk_fire) begin
            resp_reg <= mirror_reg;
            if (mirror_reg) begin
               q_reg      <= ~q_reg;
               mirror_reg <= 1'b0;
            end
         end
      end
   end

   assign q_mirror   = q_reg;
   assign bus.resp_q = resp_reg;
`else
   assign q_mirror   = 1'b0;
   assign bus.resp_q = 1'b0;
`endif

   assign a_tgl   = a_reg;
   assign clk_tgl = clk_reg;
   assign bus.ack = ack_reg;
   assign busy    = (state_reg != ST_IDLE);
endmodule

// File: tb/tb_dfft_pulse_sched.sv
// Directed bench for dfft_pulse_sched (N_REQ=4, GAP_CYC=2, BEGIN_CYC=8); mirror
// expectations follow DFFT_SCHED_MIRROR_EN.
module tb_dfft_pulse_sched;

   logic clk;
   logic rst;
   logic a_tgl;
   logic clk_tgl;
   logic q_mirror;
   logic busy;

   int assert_cnt;
   int fail_cnt;
   bit m_mirror;
   bit m_q;

   dfft_pulse_sched_if #(.N_REQ(4)) bus ();

   dfft_pulse_sched #(.N_REQ(4), .GAP_CYC(2), .BEGIN_CYC(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus.slave),
      .a_tgl    (a_tgl),
      .clk_tgl  (clk_tgl),
      .q_mirror (q_mirror),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      assert_cnt++;
      if (got !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Precondition: DUT idle at this negedge and will grant idx on the next edge.
   // mode 1 drops req[idx] on ack, mode 2 drops it right after the grant edge.
   task automatic expect_txn(input int idx, input bit b, input int mode);
      logic       a0, c0, na0, nc0, exp_a;
      logic [3:0] oh;
      bit         exp_resp;
      a0  = a_tgl;
      c0  = clk_tgl;
      na0 = ~a0;
      nc0 = ~c0;
      oh  = 4'b0001 << idx;
      step();
      if (mode == 2) bus.req[idx] = 1'b0;
      if (b) begin
         chk("load_a", a_tgl, na0);
         chk("load_clk", clk_tgl, c0);
         chk("load_ack", bus.ack, 4'b0000);
         m_mirror = 1'b1;
         step();
         chk("settle_clk", clk_tgl, c0);
         chk("settle_ack", bus.ack, 4'b0000);
         step();
      end
`ifdef DFFT_SCHED_MIRROR_EN
      exp_resp = m_mirror;
      if (m_mirror) begin
         m_q      = ~m_q;
         m_mirror = 1'b0;
      end
`else
      exp_resp = 1'b0;
      m_mirror = 1'b0;
`endif
      exp_a = b ? na0 : a0;
      chk("fire_clk", clk_tgl, nc0);
      chk("fire_a", a_tgl, exp_a);
      chk("ack", bus.ack, oh);
      chk("resp_q", bus.resp_q, exp_resp);
      chk("q_mirror", q_mirror, m_q);
      $display("txn idx=%0d bit=%0d ack=%b resp_q=%0d q_mirror=%0d", idx, b, bus.ack, bus.resp_q, q_mirror);
      if (mode == 1) bus.req[idx] = 1'b0;
      step();
      chk("ack_clear", bus.ack, 4'b0000);
      chk("resp_clear", bus.resp_q, 1'b0);
      chk("recov_busy1", busy, 1'b1);
      step();
      chk("recov_busy2", busy, 1'b1);
      step();
      chk("recov_done", busy, 1'b0);
   endtask

   // Reset has just been released at this negedge.
   task automatic init_window();
      for (int k = 1; k <= 8; k++) begin
         step();
         chk("init_quiet", {bus.ack, a_tgl, clk_tgl}, 6'b000000);
         chk("init_busy", busy, (k < 8));
      end
   endtask

   task automatic chk_reset_outputs();
      chk("rst_a", a_tgl, 1'b0);
      chk("rst_clk", clk_tgl, 1'b0);
      chk("rst_ack", bus.ack, 4'b0000);
      chk("rst_resp", bus.resp_q, 1'b0);
      chk("rst_q", q_mirror, 1'b0);
      chk("rst_busy", busy, 1'b1);
   endtask

   initial begin
      logic na;
      int   order [5];
      assert_cnt  = 0;
      fail_cnt    = 0;
      m_mirror    = 1'b0;
      m_q         = 1'b0;
      rst         = 1'b1;
      bus.req     = 4'b0001;
      bus.req_bit = 4'b0001;
      @(negedge clk);
      step();
      step();
      chk_reset_outputs();
      rst = 1'b0;

      // Startup delay, then first grant loads requester 0
      init_window();
      expect_txn(0, 1'b1, 1);

      // Load-then-read on requester 1
      bus.req = 4'b0010; bus.req_bit = 4'b0010;
      expect_txn(1, 1'b1, 1);

      // Read-only on requester 2
      bus.req = 4'b0100; bus.req_bit = 4'b0000;
      expect_txn(2, 1'b0, 1);

      // No requests: nothing moves
      for (int k = 0; k < 3; k++) begin
         step();
         chk("idle_quiet", {bus.ack, a_tgl, clk_tgl, busy}, {4'b0000, a_tgl === 1'b0 ? 1'b0 : 1'b1, clk_tgl === 1'b0 ? 1'b0 : 1'b1, 1'b0});
      end

      // Pointer at 3 with only 0 and 1 requesting wraps to 0, then 1
      bus.req = 4'b0011; bus.req_bit = 4'b0000;
      expect_txn(0, 1'b0, 1);
      expect_txn(1, 1'b0, 1);
      bus.req = 4'b1000;
      expect_txn(3, 1'b0, 1);

      // All requesting continuously
      order = '{0, 1, 2, 3, 0};
      bus.req = 4'b1111; bus.req_bit = 4'b1111;
      for (int k = 0; k < 5; k++) expect_txn(order[k], 1'b1, 0);
      bus.req = 4'b0000;

      // Request withdrawn after grant still completes
      bus.req = 4'b0010; bus.req_bit = 4'b0010;
      expect_txn(1, 1'b1, 2);

      // Reset during SETTLE aborts without ack and clears the pointer
      bus.req = 4'b0001; bus.req_bit = 4'b0001;
      na = ~a_tgl;
      step();
      chk("abort_load_a", a_tgl, na);
      step();
      chk("abort_settle_ack", bus.ack, 4'b0000);
      rst = 1'b1;
      step();
      chk_reset_outputs();
      m_mirror = 1'b0;
      m_q      = 1'b0;
      rst      = 1'b0;
      bus.req = 4'b0101; bus.req_bit = 4'b0101;
      init_window();
      expect_txn(0, 1'b1, 1);
      expect_txn(2, 1'b1, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule
